// File: rtl/psram_req_arb.sv
// Round-robin arbiter and sequencer sharing one PSRAM controller port among NUM_REQ
// requesters. One single-word transfer at a time. A watchdog aborts transfers whose
// completion never arrives.
`timescale 1ns / 1ps

module psram_req_arb #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0]         req_wdata_i,
    input  logic [NUM_REQ*4-1:0]          req_wstrb_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [31:0]                   req_rdata_o,
    output logic                          mem_valid_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    output logic [3:0]                    mem_wstrb_o,
    input  logic                          mem_ready_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          timeout_o
);

    localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned AbortAt  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    // Counter value seen on the cycle the abort decision is taken (TIMEOUT-th ISSUE cycle).
    localparam logic [CntW-1:0] CntAbort = CntW'(AbortAt);
    localparam logic [CntW-1:0] CntSat   = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_REQ-1:0]     hi_mask;
    logic [NUM_REQ-1:0]     req_hi;
    logic [IdxW-1:0]        win_idx;
    logic                   win_found;

    // Round-robin pick: lowest valid index above the last winner, else lowest valid overall.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask[k] = (k > int'(last_q));
        end
        req_hi    = req_valid_i & hi_mask;
        win_found = |req_valid_i;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) win_idx = IdxW'(k);
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_hi[k]) win_idx = IdxW'(k);
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StIssue;
                    last_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    valid_d          = 1'b1;
                    addr_d           = req_addr_i[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d          = req_wdata_i[32'(win_idx) * 32 +: 32];
                    wstrb_d          = req_wstrb_i[32'(win_idx) * 4 +: 4];
                    cnt_d            = '0;
                end
            end
            StIssue: begin
                if (mem_ready_i) begin
                    // Completion wins over an abort decided in the same cycle.
                    valid_d = 1'b0;
                    rdata_d = mem_rdata_i;
                    state_d = StDone;
                end else begin
                    if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
                    if (TIMEOUT != 0 && cnt_q == CntAbort) begin
                        valid_d   = 1'b0;
                        rdata_d   = '0;
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            last_q    <= IdxW'(NUM_REQ - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready_o = (state_q == StDone) ? grant_q : '0;
    assign req_rdata_o = rdata_q;
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign grant_o     = grant_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_psram_req_arb.sv
// Scoreboard bench for psram_req_arb: a transaction-level model predicts each grant and
// completion (cycle, owner, payload, result); a monitor compares the DUT against it.
`timescale 1ns / 1ps

module tb_psram_req_arb;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 24;
    localparam int unsigned TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_wstrb;
    logic [N-1:0]      req_ready_o;
    logic [31:0]       req_rdata_o;
    logic              mem_valid_o;
    logic [AW-1:0]     mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    psram_req_arb #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_ready_o (req_ready_o),
        .req_rdata_o (req_rdata_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // One expected transfer: grant cycle, completion (ready) cycle, owner, payload, result.
    typedef struct {
        int          g;
        int          d;
        int          own;
        logic [AW-1:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] rd;
        bit          tmo;
    } exp_t;

    exp_t q[$];

    // Requester-side state driven by the bench.
    logic [N-1:0]  vld;
    logic [AW-1:0] p_addr [N];
    logic [31:0]   p_wd   [N];
    logic [3:0]    p_ws   [N];

    // Transaction-level model of the arbiter.
    bit          m_busy;
    int          m_g, m_d, m_r, m_own, m_last, n_grant;
    logic [31:0] m_data;

    // Knobs.
    bit           rand_on, scr_on, spur_on, force_data_on;
    int           force_lat;      // -2 random, -1 never respond, >=0 cycles after grant
    logic [31:0]  force_data;
    logic [N-1:0] rearm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req_valid[k]             = vld[k];
            req_addr[k*AW +: AW]     = p_addr[k];
            req_wdata[k*32 +: 32]    = p_wd[k];
            req_wstrb[k*4 +: 4]      = p_ws[k];
        end
    endtask

    task automatic rnd_payload(input int k);
        p_addr[k] = AW'($urandom());
        p_wd[k]   = $urandom();
        p_ws[k]   = ($urandom_range(1) == 1) ? 4'($urandom()) : 4'h0;
    endtask

    task automatic raise(input int k, input logic [AW-1:0] a, input logic [31:0] w,
                         input logic [3:0] s);
        vld[k]    = 1'b1;
        p_addr[k] = a;
        p_wd[k]   = w;
        p_ws[k]   = s;
    endtask

    function automatic int pick_lat();
        int r = int'($urandom_range(9));
        if (r < 6) return int'($urandom_range(6));
        if (r == 6) return int'(TO) - 1;
        if (r == 7) return int'($urandom_range(TO - 2, 7));
        return -1;
    endfunction

    // One cycle of bench activity, executed just after the rising edge.
    task automatic step();
        exp_t e;
        bit   found;
        int   win;
        int   lat;
        if (m_busy && cyc > m_d) m_busy = 0;
        if (m_busy && cyc == m_d) begin
            if (rearm[m_own]) rnd_payload(m_own);
            vld[m_own] = rearm[m_own];
        end
        if (rand_on) begin
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && !(m_busy && m_own == k) && $urandom_range(3) == 0) begin
                    vld[k] = 1'b1;
                    rnd_payload(k);
                end
            end
        end
        // The owner may change its inputs or drop valid once granted.
        if (scr_on && m_busy && cyc < m_d && $urandom_range(1) == 0) begin
            rnd_payload(m_own);
            if ($urandom_range(3) == 0) vld[m_own] = 1'b0;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom();
        if (m_busy && cyc == m_r) begin
            mem_ready = 1'b1;
            mem_rdata = m_data;
        end else if (spur_on && (!m_busy || cyc >= m_d) && $urandom_range(3) == 0) begin
            mem_ready = 1'b1;
        end
        if (!m_busy && vld != '0) begin
            found = 0;
            win   = 0;
            for (int i = 1; i <= N; i++) begin
                if (!found && vld[(m_last + i) % N]) begin
                    found = 1;
                    win   = (m_last + i) % N;
                end
            end
            lat    = (force_lat != -2) ? force_lat : pick_lat();
            m_own  = win;
            m_last = win;
            m_busy = 1;
            m_g    = cyc + 1;
            e.g    = m_g;
            e.own  = win;
            e.addr = p_addr[win];
            e.wd   = p_wd[win];
            e.ws   = p_ws[win];
            if (lat >= 0) begin
                m_r    = m_g + lat;
                m_d    = m_r + 1;
                m_data = force_data_on ? force_data : $urandom();
                e.rd   = m_data;
                e.tmo  = 0;
            end else begin
                m_r   = -1;
                m_d   = m_g + int'(TO);
                e.rd  = '0;
                e.tmo = 1;
            end
            e.d = m_d;
            q.push_back(e);
            n_grant++;
        end
        apply();
    endtask

    task automatic cycle_step();
        @(posedge clk_i);
        #1;
        step();
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_busy || vld != '0) && guard < 400) begin
            cycle_step();
            guard++;
        end
        chk("drain_bound", 64'(m_busy || (vld != '0)), 64'(0));
        repeat (3) cycle_step();
    endtask

    task automatic reset_checks();
        chk("rst_mem_valid", 64'(mem_valid_o), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
        chk("rst_mem_wstrb", 64'(mem_wstrb_o), 64'(0));
        chk("rst_req_ready", 64'(req_ready_o), 64'(0));
        chk("rst_req_rdata", 64'(req_rdata_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
    endtask

    // Monitor: compares DUT outputs each cycle against the head of the expectation queue.
    initial begin
        exp_t         cur;
        bit           have;
        bit           act_c;
        bit           don_c;
        logic [N-1:0] oh;
        have = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                have = 0;
            end else begin
                if (q.size() != 0 && q[0].g == cyc) begin
                    cur  = q.pop_front();
                    have = 1;
                end
                act_c = have && cyc >= cur.g && cyc < cur.d;
                don_c = have && cyc == cur.d;
                oh    = '0;
                if (have) oh[cur.own] = 1'b1;
                chk("mem_valid", 64'(mem_valid_o), 64'(act_c));
                chk("grant", 64'(grant_o), 64'((act_c || don_c) ? oh : '0));
                if (act_c) begin
                    chk("mem_addr", 64'(mem_addr_o), 64'(cur.addr));
                    chk("mem_wdata", 64'(mem_wdata_o), 64'(cur.wd));
                    chk("mem_wstrb", 64'(mem_wstrb_o), 64'(cur.ws));
                end
                chk("req_ready", 64'(req_ready_o), 64'(don_c ? oh : '0));
                chk("timeout", 64'(timeout_o), 64'(don_c && cur.tmo));
                if (don_c) begin
                    chk("req_rdata", 64'(req_rdata_o), 64'(cur.rd));
                    have = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    // Stimulus sequence.
    initial begin
        vld           = '0;
        rearm         = '0;
        rand_on       = 0;
        scr_on        = 0;
        spur_on       = 0;
        force_data_on = 0;
        force_data    = '0;
        force_lat     = -2;
        m_busy        = 0;
        m_last        = N - 1;
        m_g           = 0;
        m_d           = 0;
        m_r           = -1;
        m_own         = 0;
        m_data        = '0;
        n_grant       = 0;
        for (int k = 0; k < N; k++) rnd_payload(k);
        mem_ready = 1'b0;
        mem_rdata = '0;
        apply();
        rst_n_i = 1'b1;
        #2 rst_n_i = 1'b0;
        #1 reset_checks();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;

        // Requesters 0 and 1 continuously valid: strict alternation starting at 0.
        force_lat = 2;
        raise(0, 24'h00_0100, 32'h1111_0000, 4'h0);
        raise(1, 24'h00_0200, 32'h2222_0000, 4'hF);
        rearm = 3'b011;
        for (int g = 0; g < 200 && n_grant < 6; g++) cycle_step();
        chk("rotation_grants", 64'(n_grant >= 6), 64'(1));
        rearm = '0;
        drain();

        // Single read from requester 0, controller answers 5 cycles after grant.
        force_lat     = 5;
        force_data_on = 1;
        force_data    = 32'hCAFE_F00D;
        raise(0, 24'h00_4000, 32'h0, 4'h0);
        drain();
        force_data_on = 0;

        // Partial write; owner scrambles its inputs while the transfer is in flight.
        force_lat = 8;
        scr_on    = 1;
        raise(0, 24'h00_1234, 32'hA5A5_5A5A, 4'b0011);
        drain();
        scr_on = 0;

        // Watchdog abort, then a pending requester answered on the abort-decision cycle.
        force_lat = -1;
        raise(2, 24'h00_0ABC, 32'h0, 4'h0);
        cycle_step();
        force_lat = int'(TO) - 1;
        repeat (3) cycle_step();
        raise(1, 24'h00_0DEF, 32'h3333_4444, 4'h0);
        drain();

        // Spurious controller completions while idle.
        spur_on = 1;
        repeat (12) cycle_step();
        spur_on = 0;

        // Randomised traffic.
        force_lat = -2;
        rand_on   = 1;
        scr_on    = 1;
        spur_on   = 1;
        repeat (3000) cycle_step();
        rand_on = 0;
        scr_on  = 0;
        drain();
        spur_on = 0;

        // Reset in the middle of ISSUE.
        force_lat = -1;
        raise(2, 24'h00_0777, 32'h0, 4'h0);
        repeat (4) cycle_step();
        #2 rst_n_i = 1'b0;
        #1 reset_checks();
        q.delete();
        m_busy    = 0;
        m_last    = N - 1;
        vld       = '0;
        mem_ready = 1'b0;
        apply();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        force_lat = 3;
        raise(0, 24'h00_0010, 32'h0, 4'h0);
        raise(1, 24'h00_0020, 32'h0, 4'h0);
        drain();

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_req_arb.md
# psram_req_arb

Round-robin arbiter and sequencer in front of the single PSRAM controller. It shares one PSRAM port among `NUM_REQ` native memory requesters (core data port, DMA, display fetch) and serialises their single-word transfers. It holds the granted request on the PSRAM port until the controller completes, then returns read data and a one-cycle ready. A watchdog ends any transfer whose completion never arrives, so a hung PSRAM cannot lock the bus.

## Interface
Parameters
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 24: PSRAM byte-address width.
- `TIMEOUT`, 1024: maximum cycles in ISSUE before abort. 0 disables the watchdog.

Ports
- `clk_i` in 1: system clock (`s_sys_clk` domain).
- `rst_n_i` in 1: asynchronous active-low reset.
- `req_valid_i` in NUM_REQ: per-requester request.
- `req_addr_i` in NUM_REQ*ADDR_WIDTH: packed addresses, requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata_i` in NUM_REQ*32: packed write data.
- `req_wstrb_i` in NUM_REQ*4: packed byte strobes. All zero means read.
- `req_ready_o` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `req_rdata_o` out 32: shared read data, valid while any `req_ready_o` bit is high.
- `mem_valid_o` out 1: request to the PSRAM controller.
- `mem_addr_o` out ADDR_WIDTH: address to the controller.
- `mem_wdata_o` out 32: write data to the controller.
- `mem_wstrb_o` out 4: byte strobes to the controller.
- `mem_ready_i` in 1: controller completion, one cycle.
- `mem_rdata_i` in 32: controller read data, valid with `mem_ready_i`.
- `grant_o` out NUM_REQ: one-hot owner of the current transfer. All zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog aborts a transfer.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if any `req_valid_i` bit is set, select the winner by round-robin and go to ISSUE. On the transition:
  - register `grant_o`, `mem_addr_o`, `mem_wdata_o` and `mem_wstrb_o` from the winner's slice;
  - set `mem_valid_o` to 1;
  - clear the watchdog counter.
- Round-robin: search starts at `last+1` modulo NUM_REQ, where `last` is the index of the previous winner. `last` updates on every grant.
- ISSUE:
  - Hold `mem_valid_o` and the payload stable.
  - On `mem_ready_i`: clear `mem_valid_o`, capture `mem_rdata_i` into `req_rdata_o`, go to DONE.
  - The watchdog counter increments each cycle without `mem_ready_i`. When it reaches TIMEOUT: clear `mem_valid_o`, set `req_rdata_o` to 32'h0, pulse `timeout_o`, go to DONE.
- DONE:
  - `req_ready_o[grant]` is high for exactly this cycle.
  - `grant_o` clears at the end of this cycle; next state is IDLE.
  - No arbitration takes place in DONE.
- Requesters hold valid and payload until their ready. If valid is dropped during ISSUE, the transfer still completes and ready still pulses. The payload is registered, so later input changes are ignored.
- A `mem_ready_i` arriving in IDLE or DONE is ignored.
- `req_valid_i` bits of non-granted requesters have no effect until the next IDLE.

## Timing
- Reset, asynchronous, all outputs: `mem_valid_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_wstrb_o`=0, `req_ready_o`=0, `req_rdata_o`=0, `grant_o`=0, `timeout_o`=0. State=IDLE, `last`=NUM_REQ-1 (requester 0 wins first), counter=0.
- Reset asserted mid-transfer: all of the above apply immediately. No ready pulse is produced for the aborted transfer.
- Request sampled in IDLE at cycle T: `mem_valid_o` and `grant_o` are high from T+1.
- `mem_ready_i` at cycle M: `req_ready_o` and `req_rdata_o` at M+1; IDLE at M+2; next `mem_valid_o` at M+3 at the earliest.
- Minimum transfer period: 3 cycles plus controller latency.
- Timeout: with grant at T+1, the abort decision is at T+TIMEOUT and `timeout_o` plus ready pulse at T+TIMEOUT+1. If `mem_ready_i` arrives in the same cycle as the abort decision, the normal completion wins and `timeout_o` stays 0.
- Watchdog counter width is `$clog2(TIMEOUT+1)` and it saturates, never wrapping.

## Test plan
- Single read, requester 0: controller returns `mem_ready_i` with rdata 32'hCAFEF00D 5 cycles after `mem_valid_o` -> one `req_ready_o[0]` pulse with `req_rdata_o`=32'hCAFEF00D. Check the exact cycle offsets above.
- Requesters 0 and 1 both valid continuously for 6 transfers -> grant order 0,1,0,1,0,1, each request served in turn, no starvation. `mem_addr_o` matches the owner's slice.
- Write with wstrb 4'b0011, addr 24'h00_1234 -> `mem_wstrb_o`=4'b0011 and `mem_addr_o`=24'h001234, held unchanged until `mem_ready_i` even when requester inputs change after grant.
- TIMEOUT=16, controller never responds -> `timeout_o` plus ready pulse with rdata 0 exactly 16 cycles after grant. Next pending requester is granted afterwards. Repeat with `mem_ready_i` on the abort-decision cycle -> normal completion, no `timeout_o`.
- `rst_n_i` asserted during ISSUE -> all outputs 0 at once. After release, requester 0 wins a simultaneous 0/1 request.
- Spurious `mem_ready_i` in IDLE -> no `req_ready_o`, no state change.
